// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared state encoding and width helper for the row-stationary
//               conv1d processing element.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_W   = 3'd1,
    ST_LOAD_A   = 3'd2,
    ST_GET_PSUM = 3'd3,
    ST_MAC      = 3'd4,
    ST_OUT      = 3'd5
  } state_t;

  // Bits needed to index n distinct values, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_rs_conv1d_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_rs_conv1d_if
// Description : Stream bundle of the conv1d PE: weight, activation and psum
//               inputs plus the result output, all valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_rs_conv1d_if #(
  parameter int DATA_W = 16,
  parameter int PSUM_W = 32
);
  logic              wght_valid;
  logic [DATA_W-1:0] wght_data;
  logic              wght_ready;
  logic              act_valid;
  logic [DATA_W-1:0] act_data;
  logic              act_ready;
  logic              psum_in_valid;
  logic [PSUM_W-1:0] psum_in;
  logic              psum_in_ready;
  logic              out_valid;
  logic [PSUM_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output wght_valid, wght_data, act_valid, act_data,
           psum_in_valid, psum_in, out_ready,
    input  wght_ready, act_ready, psum_in_ready, out_valid, out_data
  );

  modport slave (
    input  wght_valid, wght_data, act_valid, act_data,
           psum_in_valid, psum_in, out_ready,
    output wght_ready, act_ready, psum_in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pe_spad_bank.sv
`default_nettype none
// ============================================================================
// Module      : pe_spad_bank
// Description : Weight and activation scratchpads; registered write,
//               combinational read, out-of-range accesses ignored / read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_spad_bank
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K_MAX  = 5,
  parameter int A_MAX  = 32,
  parameter int N_FILT = 4,
  parameter int FW     = 3,
  parameter int KW     = 3,
  parameter int AW     = 6,
  parameter int AIW    = 6
) (
  input  wire logic              clk,
  input  wire logic              i_w_we,
  input  wire logic [FW-1:0]     i_w_f,
  input  wire logic [KW-1:0]     i_w_k,
  input  wire logic [DATA_W-1:0] i_w_wdata,
  input  wire logic              i_a_we,
  input  wire logic [AW-1:0]     i_a_waddr,
  input  wire logic [DATA_W-1:0] i_a_wdata,
  input  wire logic [FW-1:0]     i_rd_f,
  input  wire logic [KW-1:0]     i_rd_k,
  input  wire logic [AIW-1:0]    i_rd_a,
  output logic      [DATA_W-1:0] o_w_rdata,
  output logic      [DATA_W-1:0] o_a_rdata
);
  localparam int c_FI = cnt_w(N_FILT);
  localparam int c_KI = cnt_w(K_MAX);
  localparam int c_AI = cnt_w(A_MAX);

  logic [DATA_W-1:0] r_wmem [N_FILT][K_MAX];
  logic [DATA_W-1:0] r_amem [A_MAX];

  logic w_wr_in, w_ar_in, w_rw_in, w_ra_in;

  assign w_wr_in = (i_w_f < FW'(N_FILT)) && (i_w_k < KW'(K_MAX));
  assign w_ar_in = (i_a_waddr < AW'(A_MAX));
  assign w_rw_in = (i_rd_f < FW'(N_FILT)) && (i_rd_k < KW'(K_MAX));
  assign w_ra_in = (i_rd_a < AIW'(A_MAX));

  always_ff @(posedge clk) begin
    if (i_w_we && w_wr_in)
      r_wmem[i_w_f[c_FI-1:0]][i_w_k[c_KI-1:0]] <= i_w_wdata;
    if (i_a_we && w_ar_in)
      r_amem[i_a_waddr[c_AI-1:0]] <= i_a_wdata;
  end

  assign o_w_rdata = w_rw_in ? r_wmem[i_rd_f[c_FI-1:0]][i_rd_k[c_KI-1:0]] : '0;
  assign o_a_rdata = w_ra_in ? r_amem[i_rd_a[c_AI-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/pe_rs_conv1d.sv
`default_nettype none
// ============================================================================
// Module      : pe_rs_conv1d
// Description : Row-stationary PE computing F filters x (A-K+1) positions of a
//               1-D convolution with optional psum accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_rs_conv1d
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PSUM_W = 32,
  parameter int K_MAX  = 5,
  parameter int A_MAX  = 32,
  parameter int N_FILT = 4,
  localparam int c_KW  = cnt_w(K_MAX + 1),
  localparam int c_AW  = cnt_w(A_MAX + 1),
  localparam int c_FW  = cnt_w(N_FILT + 1),
  localparam int c_AIW = cnt_w(A_MAX + K_MAX)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic [c_KW-1:0] cfg_k,
  input  wire logic [c_AW-1:0] cfg_a,
  input  wire logic [c_FW-1:0] cfg_nf,
  input  wire logic            cfg_psum_en,
  pe_rs_conv1d_if.slave        bus,
  input  wire logic            start,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);
  state_t r_state, w_state_nx;

  logic              r_w_loaded, r_a_loaded;
  logic [c_FW-1:0]   r_ld_f;
  logic [c_KW-1:0]   r_ld_k;
  logic [c_AW-1:0]   r_ld_a;
  logic [c_KW-1:0]   r_k, r_tap;
  logic [c_AW-1:0]   r_a, r_pos;
  logic [c_FW-1:0]   r_nf, r_filt;
  logic              r_psum_en;
  logic [PSUM_W-1:0] r_acc;
  logic              r_done, r_cfg_err;

  logic w_wght_ready, w_act_ready, w_psum_ready;
  logic w_start_ok, w_start_bad, w_cfg_legal;
  logic w_wbeat, w_abeat, w_wk_last, w_wf_last, w_w_last, w_a_last;
  logic w_tap_last, w_filt_last, w_pos_last;
  logic [c_AIW-1:0]         w_a_idx;
  logic [DATA_W-1:0]        w_wq, w_aq;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [PSUM_W-1:0]        w_prod_ext;

  // Load progress follows the live config; compute uses the copy latched at start.
  assign w_wk_last = (cfg_k == '0) || (r_ld_k == cfg_k - c_KW'(1));
  assign w_wf_last = (cfg_nf == '0) || (r_ld_f == cfg_nf - c_FW'(1));
  assign w_w_last  = w_wk_last && w_wf_last;
  assign w_a_last  = (cfg_a == '0) || (r_ld_a == cfg_a - c_AW'(1));

  assign w_cfg_legal = (cfg_k != '0) && (cfg_k <= c_KW'(K_MAX)) &&
                       (cfg_a >= c_AW'(cfg_k)) && (cfg_a <= c_AW'(A_MAX)) &&
                       (cfg_nf != '0) && (cfg_nf <= c_FW'(N_FILT));

  assign w_tap_last  = (r_tap == r_k - c_KW'(1));
  assign w_filt_last = (r_filt == r_nf - c_FW'(1));
  assign w_pos_last  = (r_pos == r_a - c_AW'(r_k));

  assign w_wbeat = bus.wght_valid && w_wght_ready;
  assign w_abeat = bus.act_valid && w_act_ready;

  assign w_a_idx    = c_AIW'(r_pos) + c_AIW'(r_tap);
  assign w_prod     = $signed(w_wq) * $signed(w_aq);
  assign w_prod_ext = PSUM_W'(w_prod);

  pe_spad_bank #(
    .DATA_W (DATA_W),
    .K_MAX  (K_MAX),
    .A_MAX  (A_MAX),
    .N_FILT (N_FILT),
    .FW     (c_FW),
    .KW     (c_KW),
    .AW     (c_AW),
    .AIW    (c_AIW)
  ) u_spad (
    .clk       (clk),
    .i_w_we    (w_wbeat),
    .i_w_f     (r_ld_f),
    .i_w_k     (r_ld_k),
    .i_w_wdata (bus.wght_data),
    .i_a_we    (w_abeat),
    .i_a_waddr (r_ld_a),
    .i_a_wdata (bus.act_data),
    .i_rd_f    (r_filt),
    .i_rd_k    (r_tap),
    .i_rd_a    (w_a_idx),
    .o_w_rdata (w_wq),
    .o_a_rdata (w_aq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_wght_ready = 1'b0;
    w_act_ready  = 1'b0;
    w_psum_ready = 1'b0;
    w_start_ok   = 1'b0;
    w_start_bad  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Weights take priority, so activations are refused while weights are offered.
        w_wght_ready = ~reset;
        w_act_ready  = ~reset & ~bus.wght_valid;
        if (bus.wght_valid) begin
          if (!w_w_last) w_state_nx = ST_LOAD_W;
        end else if (bus.act_valid) begin
          if (!w_a_last) w_state_nx = ST_LOAD_A;
        end else if (start) begin
          if (!w_cfg_legal) begin
            w_start_bad = 1'b1;
          end else if (r_w_loaded && r_a_loaded) begin
            w_start_ok = 1'b1;
            w_state_nx = cfg_psum_en ? ST_GET_PSUM : ST_MAC;
          end
        end
      end
      ST_LOAD_W: begin
        w_wght_ready = 1'b1;
        if (bus.wght_valid && w_w_last) w_state_nx = ST_IDLE;
      end
      ST_LOAD_A: begin
        w_act_ready = 1'b1;
        if (bus.act_valid && w_a_last) w_state_nx = ST_IDLE;
      end
      ST_GET_PSUM: begin
        w_psum_ready = 1'b1;
        if (bus.psum_in_valid) w_state_nx = ST_MAC;
      end
      ST_MAC: begin
        if (w_tap_last) w_state_nx = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          if (w_filt_last && w_pos_last) w_state_nx = ST_IDLE;
          else w_state_nx = r_psum_en ? ST_GET_PSUM : ST_MAC;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w_loaded <= 1'b0;
      r_a_loaded <= 1'b0;
      r_ld_f     <= '0;
      r_ld_k     <= '0;
      r_ld_a     <= '0;
      r_k        <= '0;
      r_a        <= '0;
      r_nf       <= '0;
      r_psum_en  <= 1'b0;
      r_tap      <= '0;
      r_filt     <= '0;
      r_pos      <= '0;
      r_acc      <= '0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wbeat) begin
        r_w_loaded <= w_w_last;
        if (w_w_last) begin
          r_ld_k <= '0;
          r_ld_f <= '0;
        end else if (w_wk_last) begin
          r_ld_k <= '0;
          r_ld_f <= r_ld_f + c_FW'(1);
        end else begin
          r_ld_k <= r_ld_k + c_KW'(1);
        end
      end
      if (w_abeat) begin
        r_a_loaded <= w_a_last;
        r_ld_a     <= w_a_last ? '0 : r_ld_a + c_AW'(1);
      end
      if (w_start_bad) begin
        r_done    <= 1'b1;
        r_cfg_err <= 1'b1;
      end
      if (w_start_ok) begin
        r_cfg_err <= 1'b0;
        r_k       <= cfg_k;
        r_a       <= cfg_a;
        r_nf      <= cfg_nf;
        r_psum_en <= cfg_psum_en;
        r_tap     <= '0;
        r_filt    <= '0;
        r_pos     <= '0;
        r_acc     <= '0;
      end
      case (r_state)
        ST_GET_PSUM: if (bus.psum_in_valid) r_acc <= bus.psum_in;
        ST_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_tap <= w_tap_last ? '0 : r_tap + c_KW'(1);
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_acc <= '0;
            if (w_filt_last && w_pos_last) begin
              r_done <= 1'b1;
            end else if (w_filt_last) begin
              r_filt <= '0;
              r_pos  <= r_pos + c_AW'(1);
            end else begin
              r_filt <= r_filt + c_FW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wght_ready    = w_wght_ready;
  assign bus.act_ready     = w_act_ready;
  assign bus.psum_in_ready = w_psum_ready;
  assign bus.out_valid     = (r_state == ST_OUT);
  assign bus.out_data      = r_acc;
  assign busy              = (r_state != ST_IDLE);
  assign done              = r_done;
  assign cfg_err           = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_rs_conv1d.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_rs_conv1d
// Description : Directed self-checking bench for pe_rs_conv1d.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_rs_conv1d;

  typedef struct {
    int k;
    int a;
    int nf;
    int w[8];
    int act[8];
    int nexp;
    int exp_v[8];
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cfg_k = '0;
  logic [5:0] cfg_a = '0;
  logic [2:0] cfg_nf = '0;
  logic       cfg_psum_en = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, cfg_err;

  pe_rs_conv1d_if #(.DATA_W(16), .PSUM_W(32)) bus ();

  pe_rs_conv1d #(
    .DATA_W (16),
    .PSUM_W (32),
    .K_MAX  (5),
    .A_MAX  (32),
    .N_FILT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_k       (cfg_k),
    .cfg_a       (cfg_a),
    .cfg_nf      (cfg_nf),
    .cfg_psum_en (cfg_psum_en),
    .bus         (bus),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          stall_cnt = 0;
  logic [31:0] got_q[$];
  vec_t        vecs[5];

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    if (done) done_cnt++;
    if (bus.psum_in_ready && !bus.psum_in_valid) stall_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               name, $signed(got), got, $signed(exp_v), exp_v);
    end
  endtask

  task automatic send_w(input int d);
    int n = 0;
    bus.wght_valid = 1'b1;
    bus.wght_data  = 16'(d);
    @(negedge clk);
    while (!bus.wght_ready && n < 50) begin @(negedge clk); n++; end
    check("wght_ready", 32'(bus.wght_ready), 32'd1);
    @(posedge clk); #1;
    bus.wght_valid = 1'b0;
  endtask

  task automatic send_a(input int d);
    int n = 0;
    bus.act_valid = 1'b1;
    bus.act_data  = 16'(d);
    @(negedge clk);
    while (!bus.act_ready && n < 50) begin @(negedge clk); n++; end
    check("act_ready", 32'(bus.act_ready), 32'd1);
    @(posedge clk); #1;
    bus.act_valid = 1'b0;
  endtask

  task automatic send_p(input int d);
    int n = 0;
    bus.psum_in_valid = 1'b1;
    bus.psum_in       = 32'(d);
    @(negedge clk);
    while (!bus.psum_in_ready && n < 100) begin @(negedge clk); n++; end
    check("psum_in_ready", 32'(bus.psum_in_ready), 32'd1);
    @(posedge clk); #1;
    bus.psum_in_valid = 1'b0;
  endtask

  task automatic load_vec(input int i);
    cfg_k  = 3'(vecs[i].k);
    cfg_a  = 6'(vecs[i].a);
    cfg_nf = 3'(vecs[i].nf);
    for (int j = 0; j < vecs[i].k * vecs[i].nf; j++) send_w(vecs[i].w[j]);
    for (int j = 0; j < vecs[i].a; j++) send_a(vecs[i].act[j]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 2000) begin @(posedge clk); n++; end
    check(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic check_stream(input string name, input int i);
    check({name, "_count"}, 32'(got_q.size()), 32'(vecs[i].nexp));
    for (int j = 0; j < vecs[i].nexp; j++)
      check(name, (j < got_q.size()) ? got_q[j] : 32'hDEAD_BEEF, 32'(vecs[i].exp_v[j]));
  endtask

  initial begin
    int d0;
    int lat;

    // Directed vectors with hand-computed results.
    vecs[0].k = 3; vecs[0].a = 5; vecs[0].nf = 1;
    vecs[0].w = '{1, 2, 3, 0, 0, 0, 0, 0};
    vecs[0].act = '{1, 2, 3, 4, 5, 0, 0, 0};
    vecs[0].nexp = 3; vecs[0].exp_v = '{14, 20, 26, 0, 0, 0, 0, 0};

    vecs[1].k = 3; vecs[1].a = 5; vecs[1].nf = 2;
    vecs[1].w = '{1, 2, 3, 1, 0, -1, 0, 0};
    vecs[1].act = '{1, 2, 3, 4, 5, 0, 0, 0};
    vecs[1].nexp = 6; vecs[1].exp_v = '{14, -2, 20, -2, 26, -2, 0, 0};

    vecs[2].k = 1; vecs[2].a = 1; vecs[2].nf = 1;
    vecs[2].w = '{-32768, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].act = '{-32768, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].nexp = 1; vecs[2].exp_v = '{32'h4000_0000, 0, 0, 0, 0, 0, 0, 0};

    vecs[3].k = 5; vecs[3].a = 5; vecs[3].nf = 1;
    vecs[3].w = '{1, 1, 1, 1, 1, 0, 0, 0};
    vecs[3].act = '{1, 2, 3, 4, 5, 0, 0, 0};
    vecs[3].nexp = 1; vecs[3].exp_v = '{15, 0, 0, 0, 0, 0, 0, 0};

    vecs[4].k = 2; vecs[4].a = 3; vecs[4].nf = 2;
    vecs[4].w = '{3, -2, -4, 5, 0, 0, 0, 0};
    vecs[4].act = '{7, -1, 2, 0, 0, 0, 0, 0};
    vecs[4].nexp = 4; vecs[4].exp_v = '{23, -33, -7, 14, 0, 0, 0, 0};

    bus.wght_valid = 1'b0; bus.wght_data = '0;
    bus.act_valid = 1'b0;  bus.act_data = '0;
    bus.psum_in_valid = 1'b0; bus.psum_in = '0;
    bus.out_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_wght_ready", 32'(bus.wght_ready), 32'd0);
    check("rst_act_ready", 32'(bus.act_ready), 32'd0);
    check("rst_psum_ready", 32'(bus.psum_in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_wght_ready", 32'(bus.wght_ready), 32'd1);
    check("idle_act_ready", 32'(bus.act_ready), 32'd1);

    // Start with nothing loaded is ignored.
    cfg_k = 3'd3; cfg_a = 6'd5; cfg_nf = 3'd1;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("unloaded_busy", 32'(busy), 32'd0);
    check("unloaded_done", 32'(done_cnt), 32'd0);

    // Table-driven jobs without psum.
    for (int i = 0; i < 5; i++) begin
      load_vec(i);
      check("idle_psum_ready", 32'(bus.psum_in_ready), 32'd0);
      got_q.delete();
      d0 = done_cnt;
      pulse_start();
      check("job_busy", 32'(busy), 32'd1);
      wait_done(d0 + 1, "job_done");
      repeat (3) @(posedge clk);
      #1;
      check("job_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("job_cfg_err", 32'(cfg_err), 32'd0);
      check_stream("job_out", i);
    end

    // Psum chain with gaps on psum_in_valid.
    load_vec(0);
    cfg_psum_en = 1'b1;
    got_q.delete();
    d0 = done_cnt;
    stall_cnt = 0;
    pulse_start();
    check("psum_ready_get", 32'(bus.psum_in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(posedge clk);
      #1;
      send_p(100 * (i + 1));
    end
    wait_done(d0 + 1, "psum_done");
    cfg_psum_en = 1'b0;
    check("psum_count", 32'(got_q.size()), 32'd3);
    check("psum_out0", (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF, 32'd114);
    check("psum_out1", (got_q.size() > 1) ? got_q[1] : 32'hDEAD_BEEF, 32'd220);
    check("psum_out2", (got_q.size() > 2) ? got_q[2] : 32'hDEAD_BEEF, 32'd326);
    check("psum_stalled", 32'(stall_cnt >= 2), 32'd1);

    // Latency and output backpressure.
    bus.out_ready = 1'b0;
    got_q.delete();
    d0 = done_cnt;
    pulse_start();
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data", bus.out_data, 32'd14);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_done(d0 + 1, "bp_done");
    check_stream("bp_out", 0);

    // Illegal config: K > A.
    cfg_k = 3'd6; cfg_a = 6'd5; cfg_nf = 3'd1;
    got_q.delete();
    d0 = done_cnt;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("bad_done", 32'(done_cnt - d0), 32'd1);
    check("bad_cfg_err", 32'(cfg_err), 32'd1);
    check("bad_outputs", 32'(got_q.size()), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);

    // Legal start clears cfg_err; loaded data persists.
    cfg_k = 3'd3;
    d0 = done_cnt;
    pulse_start();
    check("recover_cfg_err", 32'(cfg_err), 32'd0);
    wait_done(d0 + 1, "recover_done");
    check_stream("recover_out", 0);

    // Reset during MAC.
    pulse_start();
    @(posedge clk); #1;
    check("mac_busy", 32'(busy), 32'd1);
    check("mac_psum_ready", 32'(bus.psum_in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wght_ready", 32'(bus.wght_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete();
    d0 = done_cnt;
    pulse_start();
    check("post_rst_busy", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_outputs", 32'(got_q.size()), 32'd0);
    check("post_rst_done", 32'(done_cnt - d0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
